// File: rtl/proc_pkg.sv
// Shared types and constants for the data-memory arbiter.
package proc_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int DMEM_ADDR_W    = 5;

  typedef enum logic [1:0] {IDLE, XFER, RDLAST, ACK} arb_state_t;
  typedef enum logic {CPU = 1'b0, DBG = 1'b1} req_id_t;

  // Big-endian byte lane select: index 0 is the word's MSB.
  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; a tie goes to the requester not granted last.
module rr_arb2
  import proc_pkg::*;
(
  input  logic    cpu_req,
  input  logic    dbg_req,
  input  req_id_t last_gnt,
  output req_id_t gnt_id
);
  always_comb begin
    gnt_id = CPU;
    if (cpu_req && dbg_req) gnt_id = (last_gnt == CPU) ? DBG : CPU;
    else if (dbg_req)       gnt_id = DBG;
  end
endmodule

// File: rtl/datmem_arbiter.sv
// Arbitrates CPU and debug word requests onto a byte-wide data memory,
// sequencing each word as four big-endian byte beats.
module datmem_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);
  localparam logic [1:0] LAST_BEAT = 2'(BYTES_PER_WORD - 1);

  arb_state_t        state, state_d;
  logic [1:0]        beat, beat_d;
  req_id_t           win, win_d, last_gnt, last_gnt_d, gnt_id;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, shf, shf_d;
  logic [31:0]       cpu_rdata_d, dbg_rdata_d;
  logic              cpu_ack_d, dbg_ack_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;

  rr_arb2 u_arb (
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
    .last_gnt (last_gnt),
    .gnt_id   (gnt_id)
  );

  assign cpu_stall = cpu_req & ~cpu_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      win       <= CPU;
      last_gnt  <= DBG;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      shf       <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      beat      <= beat_d;
      win       <= win_d;
      last_gnt  <= last_gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      shf       <= shf_d;
      cpu_rdata <= cpu_rdata_d;
      dbg_rdata <= dbg_rdata_d;
      cpu_ack   <= cpu_ack_d;
      dbg_ack   <= dbg_ack_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= (state_d != IDLE);
    end
  end

  // Memory-port outputs are computed for the cycle the next state occupies.
  always_comb begin
    state_d     = state;
    beat_d      = beat;
    win_d       = win;
    last_gnt_d  = last_gnt;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    shf_d       = shf;
    cpu_rdata_d = cpu_rdata;
    dbg_rdata_d = dbg_rdata;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          win_d       = gnt_id;
          we_d        = (gnt_id == DBG) ? dbg_we    : cpu_we;
          addr_d      = (gnt_id == DBG) ? dbg_addr  : cpu_addr;
          wdata_d     = (gnt_id == DBG) ? dbg_wdata : cpu_wdata;
          beat_d      = '0;
          state_d     = XFER;
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          mem_addr_d  = addr_d;
          mem_wdata_d = be_byte(wdata_d, 2'd0);
        end
      end
      XFER: begin
        // Synchronous read: the byte for beat n arrives during beat n+1.
        if (beat != 2'd0) shf_d = {shf[23:0], mem_rdata};
        if (beat == LAST_BEAT) begin
          state_d = we_q ? ACK : RDLAST;
          if (we_q) begin
            cpu_ack_d = (win == CPU);
            dbg_ack_d = (win == DBG);
          end
        end else begin
          beat_d      = beat + 2'd1;
          mem_en_d    = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = addr_q + ADDR_W'(beat_d);
          mem_wdata_d = be_byte(wdata_q, beat_d);
        end
      end
      RDLAST: begin
        state_d   = ACK;
        cpu_ack_d = (win == CPU);
        dbg_ack_d = (win == DBG);
        if (win == CPU) cpu_rdata_d = {shf[23:0], mem_rdata};
        else            dbg_rdata_d = {shf[23:0], mem_rdata};
      end
      ACK: begin
        last_gnt_d = win;
        beat_d     = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_datmem_arbiter.sv
// Directed bench for datmem_arbiter with a byte-wide synchronous memory model.
module tb_datmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [4:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic        cpu_ack, dbg_ack, cpu_stall;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_en, mem_we, busy;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem [32];
  logic        preload;

  int checks = 0;
  int errors = 0;

  datmem_arbiter #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h50 + 8'(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for its ack, then release.
  task automatic run_req(input logic is_dbg, input logic we, input logic [4:0] a,
                         input logic [31:0] wd, input int exp_lat, input string tag);
    int  n;
    logic got;
    if (is_dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; end
    else        begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    n = 0; got = 0;
    while (!got && n < 20) begin
      tick();
      n++;
      got = is_dbg ? dbg_ack : cpu_ack;
    end
    chk(tag, n, exp_lat);
    cpu_req = 0; dbg_req = 0;
    tick();
  endtask

  logic [7:0] wr_bytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
  int         ack_cyc [4];
  logic       ack_who [4];
  int         nack;

  initial begin
    rst_n = 0; preload = 1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    tick(); tick();
    preload = 0;
    chk("rst mem_en", mem_en, 0);
    chk("rst busy", busy, 0);
    chk("rst cpu_ack", cpu_ack, 0);
    chk("rst cpu_rdata", cpu_rdata, 0);
    chk("rst dbg_rdata", dbg_rdata, 0);
    chk("rst mem_addr", mem_addr, 0);
    rst_n = 1;
    tick();

    // CPU write, addr 4
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'd4; cpu_wdata = 32'hDEADBEEF;
    #1 chk("wr c0 stall", cpu_stall, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("wr mem_en", mem_en, 1);
      chk("wr mem_we", mem_we, 1);
      chk("wr mem_addr", mem_addr, 4 + k);
      chk("wr mem_wdata", mem_wdata, wr_bytes[k]);
      chk("wr stall", cpu_stall, 1);
      chk("wr no ack", cpu_ack, 0);
      tick();
    end
    chk("wr ack c5", cpu_ack, 1);
    chk("wr stall c5", cpu_stall, 0);
    chk("wr mem_en c5", mem_en, 0);
    cpu_req = 0;
    tick();
    chk("wr ack c6", cpu_ack, 0);
    chk("wr busy c6", busy, 0);
    chk("wr mem word", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEADBEEF);

    // CPU read-back
    run_req(0, 0, 5'd4, 32'h0, 6, "rd latency");
    chk("rd cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("rd dbg_rdata", dbg_rdata, 0);

    // Wrap-around through the top of memory
    run_req(1, 1, 5'd30, 32'h11223344, 5, "wrap wr latency");
    chk("wrap mem", {mem[30], mem[31], mem[0], mem[1]}, 32'h11223344);
    run_req(1, 0, 5'd30, 32'h0, 6, "wrap rd latency");
    chk("wrap dbg_rdata", dbg_rdata, 32'h11223344);
    chk("wrap cpu_rdata held", cpu_rdata, 32'hDEADBEEF);

    // Fairness: both requesters held through reset release
    rst_n = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'd12; cpu_wdata = 32'h01020304;
    dbg_req = 1; dbg_we = 1; dbg_addr = 5'd16; dbg_wdata = 32'hA0B0C0D0;
    tick();
    rst_n = 1;
    nack = 0;
    for (int c = 1; c <= 23; c++) begin
      tick();
      if ((cpu_ack || dbg_ack) && nack < 4) begin
        ack_cyc[nack] = c;
        ack_who[nack] = dbg_ack;
        nack++;
      end
    end
    cpu_req = 0; dbg_req = 0;
    tick();
    chk("fair ack count", nack, 4);
    chk("fair 0 who", ack_who[0], 0);
    chk("fair 1 who", ack_who[1], 1);
    chk("fair 2 who", ack_who[2], 0);
    chk("fair 3 who", ack_who[3], 1);
    chk("fair 0 cyc", ack_cyc[0], 5);
    chk("fair 1 cyc", ack_cyc[1], 11);
    chk("fair 2 cyc", ack_cyc[2], 17);
    chk("fair 3 cyc", ack_cyc[3], 23);
    chk("fair cpu mem", {mem[12], mem[13], mem[14], mem[15]}, 32'h01020304);
    chk("fair dbg mem", {mem[16], mem[17], mem[18], mem[19]}, 32'hA0B0C0D0);

    // Reset in the middle of a CPU write
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'd8; cpu_wdata = 32'hAABBCCDD;
    tick(); tick(); tick();
    chk("mid beat2 addr", mem_addr, 10);
    rst_n = 0;
    #1;
    chk("mid rst mem_en", mem_en, 0);
    chk("mid rst mem_addr", mem_addr, 0);
    chk("mid rst mem_wdata", mem_wdata, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst cpu_rdata", cpu_rdata, 0);
    chk("mid rst dbg_rdata", dbg_rdata, 0);
    cpu_req = 0;
    tick();
    chk("mid rst no ack", cpu_ack, 0);
    tick();
    chk("mid mem", {mem[8], mem[9], mem[10], mem[11]}, 32'hAABB5A5B);
    rst_n = 1;
    tick();

    // Early release of a CPU read with a debug read waiting
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd4;
    dbg_req = 1; dbg_we = 0; dbg_addr = 5'd30;
    tick(); tick();
    cpu_req = 0;
    #1 chk("early stall", cpu_stall, 0);
    for (int c = 3; c <= 6; c++) tick();
    chk("early cpu_ack c6", cpu_ack, 1);
    chk("early cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    tick();
    chk("early c7 busy", busy, 0);
    chk("early c7 mem_en", mem_en, 0);
    tick();
    chk("early dbg grant en", mem_en, 1);
    chk("early dbg grant addr", mem_addr, 30);
    for (int c = 9; c <= 13; c++) tick();
    chk("early dbg_ack c13", dbg_ack, 1);
    chk("early dbg_rdata", dbg_rdata, 32'h11223344);
    dbg_req = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
